// File: rtl/vga_dither_out.sv
// rtl/vga_dither_out.sv - 6-bit to 3-bit per channel VGA output stage with ordered/temporal dither
//
// Two-stage pipeline from the colour mapper to the VGA pins. Colour, sync and blank share
// the same 2-clock delay, so they stay aligned at the pins.
//
// Ports:
//   clk_vga      pixel clock, one pixel per clock
//   rst_n        asynchronous active-low reset
//   r_in/g_in/b_in  6-bit colour from the mapper
//   hsync_in/vsync_in  syncs, active level set by SYNC_ACTIVE_LOW
//   blank_in     1 = outside active video
//   dither_mode  00 truncate, 01 round, 10 ordered, 11 temporal ordered (latched per frame)
//   vga_r/g/b    3-bit colour to pins
//   vga_hsync/vga_vsync  syncs delayed 2 clocks, polarity unchanged

module vga_dither_out #(
    parameter logic SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_in,
    input  logic [1:0] dither_mode,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [2:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync
);

    // Level the sync pins sit at outside the sync pulse
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    localparam logic [1:0] MODE_TRUNC = 2'b00;
    localparam logic [1:0] MODE_ROUND = 2'b01;
    localparam logic [1:0] MODE_TEMP  = 2'b11;

    logic       hs_act;
    logic       vs_act;
    logic       hs_act_q;
    logic       vs_act_q;
    logic       hs_lead;
    logic       vs_lead;
    logic [1:0] x_q;
    logic [1:0] y_q;
    logic [1:0] frame_q;
    logic [1:0] mode_q;
    logic [1:0] row;
    logic [2:0] thresh;

    logic [5:0] s1_r;
    logic [5:0] s1_g;
    logic [5:0] s1_b;
    logic [2:0] s1_thresh;
    logic [1:0] s1_mode;
    logic       s1_hsync;
    logic       s1_vsync;
    logic       s1_blank;

    assign hs_act  = hsync_in ^ SYNC_IDLE;
    assign vs_act  = vsync_in ^ SYNC_IDLE;
    assign hs_lead = hs_act & ~hs_act_q;
    assign vs_lead = vs_act & ~vs_act_q;

    // Bayer 4x4 matrix already halved to a 3-bit threshold
    function automatic logic [2:0] bayer_thresh(input logic [1:0] r, input logic [1:0] c);
        logic [2:0] t;
        case ({r, c})
            4'h0: t = 3'd0;  4'h1: t = 3'd4;  4'h2: t = 3'd1;  4'h3: t = 3'd5;
            4'h4: t = 3'd6;  4'h5: t = 3'd2;  4'h6: t = 3'd7;  4'h7: t = 3'd3;
            4'h8: t = 3'd1;  4'h9: t = 3'd5;  4'hA: t = 3'd0;  4'hB: t = 3'd4;
            4'hC: t = 3'd7;  4'hD: t = 3'd3;  4'hE: t = 3'd6;  default: t = 3'd2;
        endcase
        return t;
    endfunction

    function automatic logic [2:0] quantise(input logic [5:0] c, input logic [1:0] mode,
                                            input logic [2:0] t);
        logic inc;
        case (mode)
            MODE_TRUNC: inc = 1'b0;
            MODE_ROUND: inc = c[2];
            default:    inc = (c[2:0] > t);
        endcase
        // Saturate at full scale so a bright pixel never rolls over to black
        return (c[5:3] == 3'd7) ? 3'd7 : c[5:3] + {2'b00, inc};
    endfunction

    // Temporal mode rotates the matrix row by the frame count
    assign row    = (mode_q == MODE_TEMP) ? y_q + frame_q : y_q;
    assign thresh = bayer_thresh(row, x_q);

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            x_q      <= 2'd0;
            y_q      <= 2'd0;
            frame_q  <= 2'd0;
            mode_q   <= MODE_TRUNC;
        end else begin
            hs_act_q <= hs_act;
            vs_act_q <= vs_act;
            x_q      <= hs_act ? 2'd0 : x_q + 2'd1;
            // vsync clear takes priority over an hsync edge on the same clock
            if (vs_act)
                y_q <= 2'd0;
            else if (hs_lead)
                y_q <= y_q + 2'd1;
            if (vs_lead) begin
                frame_q <= frame_q + 2'd1;
                mode_q  <= dither_mode;
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            s1_r      <= 6'd0;
            s1_g      <= 6'd0;
            s1_b      <= 6'd0;
            s1_thresh <= 3'd0;
            s1_mode   <= MODE_TRUNC;
            s1_hsync  <= SYNC_IDLE;
            s1_vsync  <= SYNC_IDLE;
            s1_blank  <= 1'b1;
            vga_r     <= 3'd0;
            vga_g     <= 3'd0;
            vga_b     <= 3'd0;
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
        end else begin
            s1_r      <= r_in;
            s1_g      <= g_in;
            s1_b      <= b_in;
            s1_thresh <= thresh;
            s1_mode   <= mode_q;
            s1_hsync  <= hsync_in;
            s1_vsync  <= vsync_in;
            s1_blank  <= blank_in;
            vga_r     <= s1_blank ? 3'd0 : quantise(s1_r, s1_mode, s1_thresh);
            vga_g     <= s1_blank ? 3'd0 : quantise(s1_g, s1_mode, s1_thresh);
            vga_b     <= s1_blank ? 3'd0 : quantise(s1_b, s1_mode, s1_thresh);
            vga_hsync <= s1_hsync;
            vga_vsync <= s1_vsync;
        end
    end

endmodule

// File: tb/tb_vga_dither_out.sv
// tb/tb_vga_dither_out.sv - scoreboard testbench for vga_dither_out

module tb_vga_dither_out;

    logic       clk_vga = 1'b0;
    logic       rst_n   = 1'b1;
    logic [5:0] r_in = '0, g_in = '0, b_in = '0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
    logic [1:0] dither_mode = 2'b00;
    logic [2:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync;

    vga_dither_out #(.SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk_vga(clk_vga), .rst_n(rst_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .dither_mode(dither_mode),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int         due;
        logic [2:0] r, g, b;
        logic       hs, vs;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    logic [5:0] specials [6] = '{6'h3F, 6'h0C, 6'h0B, 6'h3C, 6'h04, 6'h2A};

    // Reference model state, expressed as event counts since the relevant sync activity
    int   pix_idx, last_hs_clk, hs_edges, frames, mode_m;
    bit   hs_prev, vs_prev;

    always @(posedge clk_vga) cyc <= cyc + 1;

    always @(negedge clk_vga) begin
        if (rst_n && q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync} !== {e.r, e.g, e.b, e.hs, e.vs}) begin
                n_fail++;
                $display("FAIL pixel cyc=%0d got r=%0d g=%0d b=%0d hs=%0b vs=%0b required r=%0d g=%0d b=%0d hs=%0b vs=%0b",
                         cyc, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, e.r, e.g, e.b, e.hs, e.vs);
            end
        end
    end

    function automatic int ref_quant(int c, int mode, int t);
        int hi, lo, inc;
        hi  = c / 8;
        lo  = c % 8;
        inc = (mode == 0) ? 0 : (mode == 1) ? (lo >= 4) : (lo > t);
        return (hi == 7) ? 7 : hi + inc;
    endfunction

    task automatic model_reset();
        pix_idx     = 0;
        last_hs_clk = -1;
        hs_edges    = 0;
        frames      = 0;
        mode_m      = 0;
        hs_prev     = 0;
        vs_prev     = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync} !== {9'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL %s got rgb=%0d/%0d/%0d hs=%0b vs=%0b required 0/0/0 hs=1 vs=1",
                     name, vga_r, vga_g, vga_b, vga_hsync, vga_vsync);
        end
    endtask

    // Apply one pixel, push its expected output, then advance to just after the next edge
    task automatic drive(input logic [5:0] r, g, b, input bit hs, vs, bl, input logic [1:0] dm);
        exp_t x;
        int   col, y, row, t;
        r_in = r; g_in = g; b_in = b;
        hsync_in = ~hs; vsync_in = ~vs; blank_in = bl; dither_mode = dm;
        col = (pix_idx - last_hs_clk - 1) % 4;
        y   = hs_edges % 4;
        row = (mode_m == 3) ? (y + frames) % 4 : y;
        t   = bayer[row][col] / 2;
        x.due = cyc + 2;
        x.r   = bl ? 3'd0 : 3'(ref_quant(int'(r), mode_m, t));
        x.g   = bl ? 3'd0 : 3'(ref_quant(int'(g), mode_m, t));
        x.b   = bl ? 3'd0 : 3'(ref_quant(int'(b), mode_m, t));
        x.hs  = ~hs;
        x.vs  = ~vs;
        q.push_back(x);
        if (hs) last_hs_clk = pix_idx;
        if (hs && !hs_prev) hs_edges++;
        if (vs) hs_edges = 0;
        if (vs && !vs_prev) begin
            frames++;
            mode_m = int'(dm);
        end
        hs_prev = hs;
        vs_prev = vs;
        pix_idx++;
        @(posedge clk_vga);
        #1;
    endtask

    function automatic logic [5:0] pick_colour();
        if ($urandom_range(2) == 0) return specials[$urandom_range(5)];
        return 6'($urandom);
    endfunction

    task automatic run_frames(input int nf);
        logic [1:0] fmode, dm;
        bit         flat, hs, vs, bl;
        logic [5:0] rr;
        for (int f = 0; f < nf; f++) begin
            fmode = 2'($urandom);
            flat  = ($urandom_range(2) == 0);
            for (int ln = 0; ln < 6; ln++) begin
                for (int p = 0; p < 14; p++) begin
                    hs = (p < 2);
                    vs = (ln < 2);
                    bl = hs || vs || (p == 2) || ($urandom_range(9) == 0);
                    dm = ($urandom_range(19) == 0) ? 2'($urandom) : fmode;
                    rr = flat ? 6'h04 : pick_colour();
                    drive(rr, pick_colour(), pick_colour(), hs, vs, bl, dm);
                end
            end
        end
    endtask

    // Reset with outputs checked the moment it asserts, then a clean release
    task automatic apply_reset();
        exp_t x;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        q.delete();
        model_reset();
        hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
        repeat (3) @(posedge clk_vga);
        #1;
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        // Pipeline still holds reset contents for the first clock after release
        x.due = cyc + 1; x.r = 0; x.g = 0; x.b = 0; x.hs = 1'b1; x.vs = 1'b1;
        q.push_back(x);
    endtask

    initial begin
        apply_reset();
        run_frames(8);
        // Mid-line reset: assert a few clocks into a line
        for (int p = 0; p < 5; p++)
            drive(6'h2A, 6'h3F, 6'h00, p < 2, 1'b0, 1'b0, 2'b10);
        apply_reset();
        run_frames(8);
        repeat (4) @(posedge clk_vga);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
